// File: rtl/mux_32_1_pkg.sv
// mux_32_1_pkg: shared constants and select type for the 32-to-1 bit mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_32_1_pkg;

  localparam int MUX_W     = 32;
  localparam int MUX_SEL_W = 5;

  typedef logic [MUX_SEL_W-1:0] sel_t;

endpackage : mux_32_1_pkg

// File: rtl/mux_32_1_mux2_1.sv
// mux2_1: single-bit 2:1 select, the leaf cell of the 32:1 tree.
// Latency: combinational.
// Backpressure: none.
// Ports: a (picked when sel=0), b (picked when sel=1), sel, y.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  // A ternary with a known select forwards only the chosen leg, so an
  // unknown value on the unselected input never reaches y.
  assign y = sel ? b : a;

endmodule : mux2_1

// File: rtl/mux_32_1.sv
// mux_32_1: registered 32-to-1 single-bit mux, o_comb = i[s], o = i[s] registered.
// Latency: o_comb 0 cycles, o 1 cycle; o captures only when en is high.
// Backpressure: none; en low holds o, reset forces o to 0 asynchronously.
// Ports: clk, reset (async, active high), en, i[31:0], s[4:0], o, o_comb.
module mux_32_1
  import mux_32_1_pkg::*;
#(
  parameter int WIDTH = MUX_W,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  input  logic [SEL_W-1:0] s,
  output logic             o,
  output logic             o_comb
);

  sel_t sel;
  assign sel = s;

  // One vector per tree level; level n is steered by sel[n].
  logic [15:0] lvl0;
  logic [7:0]  lvl1;
  logic [3:0]  lvl2;
  logic [1:0]  lvl3;
  logic        lvl4;

  for (genvar g = 0; g < 16; g++) begin : g_lvl0
    mux2_1 u_mux (.a(i[2*g]), .b(i[2*g+1]), .sel(sel[0]), .y(lvl0[g]));
  end

  for (genvar g = 0; g < 8; g++) begin : g_lvl1
    mux2_1 u_mux (.a(lvl0[2*g]), .b(lvl0[2*g+1]), .sel(sel[1]), .y(lvl1[g]));
  end

  for (genvar g = 0; g < 4; g++) begin : g_lvl2
    mux2_1 u_mux (.a(lvl1[2*g]), .b(lvl1[2*g+1]), .sel(sel[2]), .y(lvl2[g]));
  end

  for (genvar g = 0; g < 2; g++) begin : g_lvl3
    mux2_1 u_mux (.a(lvl2[2*g]), .b(lvl2[2*g+1]), .sel(sel[3]), .y(lvl3[g]));
  end

  mux2_1 u_lvl4 (.a(lvl3[0]), .b(lvl3[1]), .sel(sel[4]), .y(lvl4));

  assign o_comb = lvl4;

  // Output register: reset wins over enable and takes effect without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o <= 1'b0;
    end else if (en) begin
      o <= lvl4;
    end
  end

endmodule : mux_32_1

// File: tb/tb_mux_32_1.sv
// tb_mux_32_1: directed self-checking bench for mux_32_1.
// Latency: checks o_comb same cycle and o one edge after capture.
// Backpressure: exercises en hold and asynchronous mid-run reset.
module tb_mux_32_1;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] i;
  logic [4:0]  s;
  logic        o;
  logic        o_comb;

  int n_cmp = 0;
  int n_err = 0;

  mux_32_1 dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .i      (i),
    .s      (s),
    .o      (o),
    .o_comb (o_comb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    i     = 32'hFFFF_FFFF;
    s     = 5'd31;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_cmp++;
      if (o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_o cycle %0d: got %b required 0", n, o);
      end
      n_cmp++;
      if (o_comb !== 1'b1) begin
        n_err++;
        $display("FAIL reset_o_comb cycle %0d: got %b required 1", n, o_comb);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got %b required 1", o);
    end
  endtask

  task automatic test_zero();
    i  = 32'h0000_0000;
    s  = 5'd0;
    en = 1'b1;
    #1;
    n_cmp++;
    if (o_comb !== 1'b0) begin
      n_err++;
      $display("FAIL zero_o_comb: got %b required 0", o_comb);
    end
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_o: got %b required 0", o);
    end
  endtask

  task automatic test_mixed();
    logic [4:0] sels [4];
    logic       exps [4];
    sels = '{5'd16, 5'd8, 5'd3, 5'd0};
    exps = '{1'b0, 1'b0, 1'b1, 1'b0};
    i  = 32'h1234_5678;
    en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      s = sels[n];
      #1;
      n_cmp++;
      if (o_comb !== exps[n]) begin
        n_err++;
        $display("FAIL mixed_o_comb s=%0d: got %b required %b", sels[n], o_comb, exps[n]);
      end
      @(negedge clk);
      n_cmp++;
      if (o !== exps[n]) begin
        n_err++;
        $display("FAIL mixed_o s=%0d: got %b required %b", sels[n], o, exps[n]);
      end
    end
  endtask

  task automatic test_all_ones();
    i  = 32'hFFFF_FFFF;
    s  = 5'd31;
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b1) begin
      n_err++;
      $display("FAIL all_ones_o: got %b required 1", o);
    end
  endtask

  task automatic test_walking_one();
    logic exp_o;
    logic have_prev;
    have_prev = 1'b0;
    exp_o     = 1'b0;
    en        = 1'b1;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 32; j++) begin
        @(negedge clk);
        if (have_prev) begin
          n_cmp++;
          if (o !== exp_o) begin
            n_err++;
            $display("FAIL walk_o k=%0d s=%0d: got %b required %b", k, j, o, exp_o);
          end
        end
        i = 32'h1 << k;
        s = 5'(j);
        exp_o = (j == k);
        #1;
        n_cmp++;
        if (o_comb !== exp_o) begin
          n_err++;
          $display("FAIL walk_o_comb k=%0d s=%0d: got %b required %b", k, j, o_comb, exp_o);
        end
        have_prev = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (o !== exp_o) begin
      n_err++;
      $display("FAIL walk_o last: got %b required %b", o, exp_o);
    end
  endtask

  task automatic test_enable_reset();
    // Capture a 1.
    i  = 32'h0000_0020;
    s  = 5'd5;
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b1) begin
      n_err++;
      $display("FAIL en_capture: got %b required 1", o);
    end
    // Hold with en low while the selected bit drops.
    en = 1'b0;
    i  = 32'h0000_0000;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_cmp++;
      if (o !== 1'b1) begin
        n_err++;
        $display("FAIL en_hold edge %0d: got %b required 1", n, o);
      end
    end
    n_cmp++;
    if (o_comb !== 1'b0) begin
      n_err++;
      $display("FAIL en_hold_o_comb: got %b required 0", o_comb);
    end
    // Reset pulse between edges, with a capture pending on the next edge.
    en = 1'b1;
    i  = 32'hFFFF_FFFF;
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %b required 0", o);
    end
    n_cmp++;
    if (o_comb !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_o_comb: got %b required 1", o_comb);
    end
    // Keep reset over the edge: the pending capture must be lost.
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_over_edge: got %b required 0", o);
    end
    reset = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_hold: got %b required 0", o);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_capture: got %b required 1", o);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    i     = 32'h0;
    s     = 5'd0;
    test_reset();
    test_zero();
    test_mixed();
    test_all_ones();
    test_walking_one();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_32_1

// File: doc/mux_32_1.md
# mux_32_1

Registered 32-to-1 single-bit multiplexer. It selects one bit of a 32-bit input word by a 5-bit index and presents it on a registered output one clock later. It is used wherever a datapath needs a single status or condition bit picked from a 32-bit word, for example a bit-test or condition-select path.

## Interface
Parameters:
- `WIDTH`, 32: number of data inputs; fixed at 32 for this block.
- `SEL_W`, 5: select width, equal to log2(WIDTH).

Ports:
- `clk`, input, 1: rising-edge clock (the design's single clock).
- `reset`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: capture enable; output register loads only when high.
- `i`, input, 32: data word; `i[0]` is the LSB.
- `s`, input, 5: select index, unsigned, 0..31.
- `o`, output, 1: registered selected bit.
- `o_comb`, output, 1: unregistered selected bit, equal to `i[s]`, for same-cycle use.

## Operation
- `o_comb = i[s]`, purely combinational, for any `s` in 0..31. Every 5-bit value is legal, so there is no out-of-range case.
- Selection is a bit pick, not a shift or rotate: exactly one bit of `i` reaches the output.
- On a rising `clk` with `en=1` and `reset=0`: `o <= i[s]`.
- On a rising `clk` with `en=0`: `o` holds its value.
- `reset=1` forces `o=0` immediately, independent of `clk` and `en`. `o` stays 0 while `reset` is asserted.
- `o_comb` is unaffected by `reset`; it always follows `i` and `s`.
- X or Z on `i` bits that are not selected must not propagate to the outputs.

## Timing
- Reset value: `o=0`. `o_comb` has no reset value; it is combinational.
- `o_comb` latency is 0 cycles, combinational from `i` and `s`.
- `o` latency is 1 cycle: the value sampled at edge N is visible after edge N.
- Reset deassertion is synchronous to `clk` at the system level. The first capture happens on the first rising edge with `reset=0` and `en=1`.
- Reset asserted mid-operation: `o` goes to 0 within the same cycle, and any pending capture is lost.
- `i` and `s` changing together before an edge: the value captured is `i[s]` at the edge, using both new values.
- Critical path is a 5-level 2:1 mux tree from `s` and `i` to the `o` D-input. It must close at the core clock with no pipelining.

## Structure
- Shared package: `MUX_W = 32` and `MUX_SEL_W = 5` constants, plus a `sel_t` typedef (5-bit unsigned).
- Sub-module `mux2_1` (inputs `a`, `b`, `sel`; output `y`). The select tree is built from it:
  - 16 instances at level 0, selected by `s[0]`.
  - Then 8, 4, 2 and 1 instances at levels 1 to 4, selected by `s[1]` to `s[4]`.
  - This structure is required so the tree is explicit and testable per level.
- The top-level block holds the output register and the enable/reset logic.

## Test plan
- Reset: `reset=1`, `i=0xFFFF_FFFF`, `s=31`, clock running. Required: `o=0` throughout, with `o_comb=1`. Release `reset`, one edge with `en=1`: `o=1`.
- Zero word: `i=0x0000_0000`, `s=0`, `en=1`. Required: `o_comb=0`, and `o=0` after one edge.
- Mixed word: `i=0x1234_5678`, `en=1`. Step `s` through 16, 8, 3 and 0, one edge each. Required `o` values: 0, 0, 1, 0. `o_comb` shows each value in the same cycle.
- All ones: `i=0xFFFF_FFFF`, `s=31`. Required: `o=1` after one edge.
- Walking one: for k=0..31, `i=1<<k`, sweep all 32 values of `s`. Required: `o_comb=1` only when `s==k`, and `o` matches it one cycle later.
- Enable and mid-run reset:
  1. Capture `o=1`.
  2. Set `en=0`, change `i` to 0 for 3 edges. Required: `o` stays 1.
  3. Pulse `reset` between edges. Required: `o=0` immediately, before the next edge.
